control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high, with ports named clock and clear.
REQ-002 The block SHALL have these ports:
- clock  in  1  system clock, rising edge
- clear  in  1  sync active-high reset
- start  in  1  begin one instruction cycle
- mem_ready  in  1  memory read data valid
- ir  in  32  DataPath IR contents
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive enables
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  out  1 each  register load enables
- IncPC, Read  out  1 each  PC increment, memory read
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-select/strobe
- alu_op  out  4  ALU operation (0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV)
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  sticky unsupported opcode flag

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs SHALL decode from the registered state and ir, and SHALL assert for the whole cycle the FSM is in that state.
REQ-004 Field decode SHALL be: opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
REQ-005 In IDLE, the FSM SHALL move to T0 when start=1; start SHALL be ignored in every other state.
REQ-006 T0 SHALL assert PCout, MARin, IncPC and Zin, and SHALL move unconditionally to T1.
REQ-007 T1 SHALL assert Zlowout, PCin, Read and MDRin. It SHALL hold in T1 while mem_ready=0 and move to T2 on mem_ready=1. PCin SHALL assert only on the exit cycle. mem_ready SHALL be ignored outside T1.
REQ-008 T2 SHALL assert MDRout and IRin, then move to T3.
REQ-009 In T3, an illegal opcode SHALL set illegal, pulse done and return to IDLE.
REQ-010 ALU ops (ADD 00000, SUB 00001, AND 00010, OR 00011):
- T3: Grb, Rout, Yin
- T4: Grc, Rout, Zin, alu_op
- T5: Zlowout, Gra, Rin, done; then IDLE
REQ-011 MUL (01110) and DIV (01111):
- T3: Gra, Rout, Yin
- T4: Grb, Rout, Zin, alu_op
- T5: Zlowout, LOin
- T6: Zhighout, HIin, done; then IDLE
REQ-012 alu_op SHALL be 0 in all states except T4.
REQ-013 busy SHALL be 1 in every non-IDLE state. done SHALL pulse exactly one cycle per instruction.
REQ-014 illegal SHALL stay set until clear or the next accepted start.
REQ-015 Simultaneous clear and start SHALL resolve to clear.

Reset
REQ-016 When clear=1 at a rising edge, the state SHALL become IDLE and illegal SHALL become 0, including mid-instruction. All outputs SHALL be 0 in the following cycle.
REQ-017 In IDLE, every output SHALL be 0.

Configuration
REQ-018 With MULDIV_EN defined, MUL and DIV SHALL be sequenced per REQ-011. Without it, opcodes 01110 and 01111 SHALL be treated as illegal, and T6, LOin, HIin and Zhighout SHALL be tied to 0.

Structure
REQ-019 A shared package SHALL hold:
- the state enum
- the opcode constants
- the alu_op encodings
- the ir field bit positions
REQ-020 The opcode-to-{alu_op, legal, is_muldiv} decode SHALL be one sub-module, opcode_decoder. The FSM and output decode SHALL stay in control_sequencer.

Verification
REQ-021 ADD (ir=32'h00918000, start, mem_ready=1 in first T1 cycle):
- T4: Grc=1, alu_op=0
- T5: Gra=1, Rin=1, done=1
- back in IDLE 7 cycles after start
REQ-022 mem_ready held 0 for 3 cycles: FSM SHALL stay in T1 4 cycles, with Read=1 throughout and PCin=1 only on the last cycle.
REQ-023 DIV (ir=32'h79180000, MULDIV_EN defined):
- T4: alu_op=5
- T5: LOin=1
- T6: HIin=1, done=1
Same case without MULDIV_EN: illegal=1 after T3, and done SHALL pulse in T3.
REQ-024 clear asserted in T4: all outputs SHALL be 0 next cycle, and busy=0.
REQ-025 start held high across an instruction: no re-entry before IDLE, and the next T0 SHALL follow the IDLE cycle.
REQ-026 Opcode 11111: illegal=1 and stays 1 through idle cycles; the next start SHALL clear it.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared definitions for the instruction control sequencer.
//   - state_e      : sequencer states (IDLE, T0..T6)
//   - Op*          : 5-bit opcode constants
//   - Alu*         : alu_op encodings driven to the datapath ALU
//   - *Msb/*Lsb    : bit positions of the opcode, ra, rb and rc fields inside IR
// Configuration macro: MULDIV_EN. When defined, MUL/DIV are sequenced; otherwise they are
// illegal opcodes and the T6 step plus LOin/HIin/Zhighout are tied off.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6
  } state_e;

  // Opcodes
  localparam logic [4:0] OpAdd = 5'b00000;
  localparam logic [4:0] OpSub = 5'b00001;
  localparam logic [4:0] OpAnd = 5'b00010;
  localparam logic [4:0] OpOr  = 5'b00011;
  localparam logic [4:0] OpMul = 5'b01110;
  localparam logic [4:0] OpDiv = 5'b01111;

  // ALU operation encodings
  localparam int unsigned AluOpW = 4;
  localparam logic [AluOpW-1:0] AluAdd = 4'd0;
  localparam logic [AluOpW-1:0] AluSub = 4'd1;
  localparam logic [AluOpW-1:0] AluAnd = 4'd2;
  localparam logic [AluOpW-1:0] AluOr  = 4'd3;
  localparam logic [AluOpW-1:0] AluMul = 4'd4;
  localparam logic [AluOpW-1:0] AluDiv = 4'd5;

  // IR field positions
  localparam int unsigned IrW       = 32;
  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaMsb     = 26;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbMsb     = 22;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcMsb     = 18;
  localparam int unsigned RcLsb     = 15;

  // Build-time switch for the multiply/divide sequence.
`ifdef MULDIV_EN
  localparam bit MulDivEn = 1'b1;
`else
  localparam bit MulDivEn = 1'b0;
`endif

  function automatic logic [4:0] ir_opcode(logic [IrW-1:0] ir_word);
    return ir_word[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: maps an instruction opcode to its ALU operation and class.
// Ports:
//   opcode_i    in  5  instruction opcode (IR[31:27])
//   alu_op_o    out 4  ALU operation for the execute step (AluAdd when not an ALU op)
//   legal_o     out 1  opcode is supported in this build
//   is_muldiv_o out 1  opcode uses the two-step LO/HI writeback sequence
// Configuration macro: MULDIV_EN (via control_sequencer_pkg::MulDivEn). Without it MUL/DIV
// decode as illegal and is_muldiv_o is never set.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0]        opcode_i,
  output logic [AluOpW-1:0] alu_op_o,
  output logic              legal_o,
  output logic              is_muldiv_o
);

  always_comb begin
    alu_op_o    = AluAdd;
    legal_o     = 1'b0;
    is_muldiv_o = 1'b0;
    case (opcode_i)
      OpAdd: begin
        alu_op_o = AluAdd;
        legal_o  = 1'b1;
      end
      OpSub: begin
        alu_op_o = AluSub;
        legal_o  = 1'b1;
      end
      OpAnd: begin
        alu_op_o = AluAnd;
        legal_o  = 1'b1;
      end
      OpOr: begin
        alu_op_o = AluOr;
        legal_o  = 1'b1;
      end
      OpMul: begin
        alu_op_o    = AluMul;
        legal_o     = MulDivEn;
        is_muldiv_o = MulDivEn;
      end
      OpDiv: begin
        alu_op_o    = AluDiv;
        legal_o     = MulDivEn;
        is_muldiv_o = MulDivEn;
      end
      default: begin
        alu_op_o    = AluAdd;
        legal_o     = 1'b0;
        is_muldiv_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM that steps the datapath through fetch (T0..T2) and execute
// (T3..T6) for one instruction per accepted start.
// Ports:
//   clock, clear                 in   rising-edge clock, synchronous active-high reset
//   start                        in   begin one instruction cycle (only honoured in IDLE)
//   mem_ready                    in   memory read data valid (only looked at in T1)
//   ir[31:0]                     in   IR contents from the datapath
//   PCout Zlowout Zhighout MDRout out  bus drive enables
//   MARin PCin MDRin IRin Yin Zin LOin HIin  out  register load enables
//   IncPC Read                   out  PC increment, memory read
//   Gra Grb Grc Rin Rout         out  register-file select and strobes
//   alu_op[3:0]                  out  ALU operation, non-zero only in T4
//   busy done illegal            out  not-idle, completion pulse, sticky bad-opcode flag
// Configuration macro: MULDIV_EN (via control_sequencer_pkg::MulDivEn) enables MUL/DIV and the
// T6 step; without it T6, LOin, HIin and Zhighout are held at 0.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [IrW-1:0]    ir,
  output logic              PCout,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              MDRout,
  output logic              MARin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              LOin,
  output logic              HIin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic [AluOpW-1:0] alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_e              state_q;
  logic                illegal_q;
  logic [4:0]          opcode;
  logic [AluOpW-1:0]   dec_alu_op;
  logic                dec_legal;
  logic                dec_is_muldiv;

  assign opcode = ir_opcode(ir);

  // Register selection itself happens in the datapath from the ra/rb/rc fields; the sequencer
  // only needs the opcode.
  logic unused_ir;
  assign unused_ir = ^{ir[RaMsb:RaLsb], ir[RbMsb:RbLsb], ir[RcMsb:RcLsb], ir[RcLsb-1:0]};

  opcode_decoder u_opcode_decoder (
    .opcode_i    (opcode),
    .alu_op_o    (dec_alu_op),
    .legal_o     (dec_legal),
    .is_muldiv_o (dec_is_muldiv)
  );

  // State and sticky flag. clear has priority over everything, including a coincident start.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StT0;
            illegal_q <= 1'b0;
          end
        end
        StT0: state_q <= StT1;
        StT1: begin
          if (mem_ready) begin
            state_q <= StT2;
          end
        end
        StT2: state_q <= StT3;
        StT3: begin
          if (!dec_legal) begin
            state_q   <= StIdle;
            illegal_q <= 1'b1;
          end else begin
            state_q <= StT4;
          end
        end
        StT4: state_q <= StT5;
        StT5: state_q <= (MulDivEn && dec_is_muldiv) ? StT6 : StIdle;
        StT6: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode from the registered state and IR. PCin is the only term that also looks at
  // mem_ready: the PC is reloaded on the single T1 cycle that leaves for T2.
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = AluAdd;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    illegal  = illegal_q;
    case (state_q)
      StIdle: ;
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (!dec_legal) begin
          done = 1'b1;
        end else if (dec_is_muldiv) begin
          // MUL/DIV take the first operand from ra.
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        Grb    = dec_is_muldiv;
        Grc    = !dec_is_muldiv;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = dec_alu_op;
      end
      StT5: begin
        Zlowout = 1'b1;
        if (dec_is_muldiv) begin
          LOin = MulDivEn;
        end else begin
          Gra  = 1'b1;
          Rin  = 1'b1;
          done = 1'b1;
        end
      end
      StT6: begin
        Zhighout = MulDivEn;
        HIin     = MulDivEn;
        done     = MulDivEn;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven and hand-written directed checks of control_sequencer,
// followed by random start/clear/mem_ready/ir stimulus checked against a queue-based
// instruction model. Honours MULDIV_EN in the same way as the design.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, busy, done, illegal;
  logic [3:0] alu_op;

  control_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [25:0] act;
  assign act = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, LOin,
                HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, busy, done, illegal};

  localparam logic [25:0] M_PCOUT    = 26'h1 << 25;
  localparam logic [25:0] M_ZLOWOUT  = 26'h1 << 24;
  localparam logic [25:0] M_ZHIGHOUT = 26'h1 << 23;
  localparam logic [25:0] M_MDROUT   = 26'h1 << 22;
  localparam logic [25:0] M_MARIN    = 26'h1 << 21;
  localparam logic [25:0] M_PCIN     = 26'h1 << 20;
  localparam logic [25:0] M_MDRIN    = 26'h1 << 19;
  localparam logic [25:0] M_IRIN     = 26'h1 << 18;
  localparam logic [25:0] M_YIN      = 26'h1 << 17;
  localparam logic [25:0] M_ZIN      = 26'h1 << 16;
  localparam logic [25:0] M_LOIN     = 26'h1 << 15;
  localparam logic [25:0] M_HIIN     = 26'h1 << 14;
  localparam logic [25:0] M_INCPC    = 26'h1 << 13;
  localparam logic [25:0] M_READ     = 26'h1 << 12;
  localparam logic [25:0] M_GRA      = 26'h1 << 11;
  localparam logic [25:0] M_GRB      = 26'h1 << 10;
  localparam logic [25:0] M_GRC      = 26'h1 << 9;
  localparam logic [25:0] M_RIN      = 26'h1 << 8;
  localparam logic [25:0] M_ROUT     = 26'h1 << 7;
  localparam logic [25:0] M_BUSY     = 26'h1 << 2;
  localparam logic [25:0] M_DONE     = 26'h1 << 1;
  localparam logic [25:0] M_ILLEGAL  = 26'h1;

  // Expected output vectors per instruction step.
  localparam logic [25:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
  localparam logic [25:0] E_T1W = M_ZLOWOUT | M_READ | M_MDRIN | M_BUSY;
  localparam logic [25:0] E_T1X = E_T1W | M_PCIN;
  localparam logic [25:0] E_T2  = M_MDROUT | M_IRIN | M_BUSY;
  localparam logic [25:0] E_A3  = M_GRB | M_ROUT | M_YIN | M_BUSY;
  localparam logic [25:0] E_A5  = M_ZLOWOUT | M_GRA | M_RIN | M_DONE | M_BUSY;
  localparam logic [25:0] E_M3  = M_GRA | M_ROUT | M_YIN | M_BUSY;
  localparam logic [25:0] E_M5  = M_ZLOWOUT | M_LOIN | M_BUSY;
  localparam logic [25:0] E_M6  = M_ZHIGHOUT | M_HIIN | M_DONE | M_BUSY;
  localparam logic [25:0] E_I3  = M_BUSY | M_DONE;

  localparam logic [31:0] IR_ADD = 32'h00918000;
  localparam logic [31:0] IR_SUB = 32'h08918000;
  localparam logic [31:0] IR_DIV = 32'h79180000;
  localparam logic [31:0] IR_BAD = 32'hF8000000;

  function automatic logic [25:0] e_a4(int unsigned op);
    return M_GRC | M_ROUT | M_ZIN | M_BUSY | (26'(op) << 3);
  endfunction

  function automatic logic [25:0] e_m4(int unsigned op);
    return M_GRB | M_ROUT | M_ZIN | M_BUSY | (26'(op) << 3);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  // Drive one cycle of inputs just after the rising edge, compare mid-cycle, advance.
  task automatic step(input logic c, input logic s, input logic m, input logic [31:0] i,
                      input logic [25:0] exp, input string name);
    clear     = c;
    start     = s;
    mem_ready = m;
    ir        = i;
    #3;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs %h, required %h", name, act, exp);
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        c;
    logic        s;
    logic        m;
    logic [31:0] i;
    logic [25:0] e;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic s, logic m, logic [31:0] i, logic [25:0] e);
    vec_t v;
    v.c = c; v.s = s; v.m = m; v.i = i; v.e = e;
    return v;
  endfunction

  // Instruction model: each accepted start becomes a queue of per-cycle expected vectors.
  typedef struct {
    logic [25:0] v;
    logic        care;    // cycle waits on memory: bench must drive mr
    logic        mr;
    logic        ill_end; // last cycle of an unsupported opcode
  } exp_t;

  exp_t q[$];
  logic sticky = 1'b0;

  function automatic exp_t ent(logic [25:0] v, logic care, logic mr, logic ill_end);
    exp_t e;
    e.v = v; e.care = care; e.mr = mr; e.ill_end = ill_end;
    return e;
  endfunction

  task automatic plan(input logic [31:0] i);
    int unsigned op;
    int unsigned waits;
    op    = int'(i[31:27]);
    waits = $urandom_range(0, 3);
    q.push_back(ent(E_T0, 1'b0, 1'b0, 1'b0));
    for (int w = 0; w < int'(waits); w++) q.push_back(ent(E_T1W, 1'b1, 1'b0, 1'b0));
    q.push_back(ent(E_T1X, 1'b1, 1'b1, 1'b0));
    q.push_back(ent(E_T2, 1'b0, 1'b0, 1'b0));
    if (op <= 3) begin
      q.push_back(ent(E_A3, 1'b0, 1'b0, 1'b0));
      q.push_back(ent(e_a4(op), 1'b0, 1'b0, 1'b0));
      q.push_back(ent(E_A5, 1'b0, 1'b0, 1'b0));
    end
`ifdef MULDIV_EN
    else if (op == 14 || op == 15) begin
      q.push_back(ent(E_M3, 1'b0, 1'b0, 1'b0));
      q.push_back(ent(e_m4(op == 14 ? 4 : 5), 1'b0, 1'b0, 1'b0));
      q.push_back(ent(E_M5, 1'b0, 1'b0, 1'b0));
      q.push_back(ent(E_M6, 1'b0, 1'b0, 1'b0));
    end
`endif
    else begin
      q.push_back(ent(E_I3, 1'b0, 1'b0, 1'b1));
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3)      r[31:27] = 5'(k);
    else if (k == 4) r[31:27] = 5'b01110;
    else if (k == 5) r[31:27] = 5'b01111;
    return r;
  endfunction

  initial begin
    logic        rc, rs, rm;
    logic [25:0] re;
    logic [31:0] cur_ir;
    exp_t        h;

    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'd0;
    @(posedge clock);
    #1;

    // ADD with immediate mem_ready, then SUB with three wait cycles in T1.
    tbl.push_back(mk(1, 0, 0, IR_ADD, 26'd0));
    tbl.push_back(mk(0, 1, 0, IR_ADD, 26'd0));
    tbl.push_back(mk(0, 0, 1, IR_ADD, E_T0));
    tbl.push_back(mk(0, 0, 1, IR_ADD, E_T1X));
    tbl.push_back(mk(0, 0, 0, IR_ADD, E_T2));
    tbl.push_back(mk(0, 0, 0, IR_ADD, E_A3));
    tbl.push_back(mk(0, 0, 0, IR_ADD, e_a4(0)));
    tbl.push_back(mk(0, 0, 0, IR_ADD, E_A5));
    tbl.push_back(mk(0, 0, 0, IR_ADD, 26'd0));
    tbl.push_back(mk(0, 1, 0, IR_SUB, 26'd0));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_T0));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_T1W));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_T1W));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_T1W));
    tbl.push_back(mk(0, 0, 1, IR_SUB, E_T1X));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_T2));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_A3));
    tbl.push_back(mk(0, 0, 0, IR_SUB, e_a4(1)));
    tbl.push_back(mk(0, 0, 0, IR_SUB, E_A5));
    tbl.push_back(mk(0, 0, 0, IR_SUB, 26'd0));
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].c, tbl[k].s, tbl[k].m, tbl[k].i, tbl[k].e, $sformatf("table[%0d]", k));
    end

    // DIV: full sequence with MULDIV_EN, illegal otherwise.
    step(0, 1, 0, IR_DIV, 26'd0, "div accept");
    step(0, 0, 0, IR_DIV, E_T0, "div T0");
    step(0, 0, 1, IR_DIV, E_T1X, "div T1");
    step(0, 0, 0, IR_DIV, E_T2, "div T2");
`ifdef MULDIV_EN
    step(0, 0, 0, IR_DIV, E_M3, "div T3");
    step(0, 0, 0, IR_DIV, e_m4(5), "div T4");
    step(0, 0, 0, IR_DIV, E_M5, "div T5");
    step(0, 0, 0, IR_DIV, E_M6, "div T6");
    step(0, 0, 0, IR_DIV, 26'd0, "div idle");
`else
    step(0, 0, 0, IR_DIV, E_I3, "div T3 illegal");
    step(0, 0, 0, IR_DIV, M_ILLEGAL, "div illegal flag");
    step(1, 0, 0, IR_DIV, M_ILLEGAL, "clear while illegal");
    step(0, 0, 0, IR_DIV, 26'd0, "illegal cleared by clear");
`endif

    // Opcode 11111: sticky through idle, cleared by next start; then clear during T4.
    step(0, 1, 0, IR_BAD, 26'd0, "bad accept");
    step(0, 0, 0, IR_BAD, E_T0, "bad T0");
    step(0, 0, 0, IR_BAD, E_T1W, "bad T1 wait");
    step(0, 0, 1, IR_BAD, E_T1X, "bad T1 exit");
    step(0, 0, 0, IR_BAD, E_T2, "bad T2");
    step(0, 0, 1, IR_BAD, E_I3, "bad T3");
    step(0, 0, 1, IR_BAD, M_ILLEGAL, "bad sticky 1");
    step(0, 0, 0, IR_BAD, M_ILLEGAL, "bad sticky 2");
    step(0, 0, 1, IR_BAD, M_ILLEGAL, "bad sticky 3");
    step(0, 1, 0, IR_ADD, M_ILLEGAL, "start over illegal");
    step(0, 0, 0, IR_ADD, E_T0, "start clears illegal");
    step(0, 0, 1, IR_ADD, E_T1X, "add T1");
    step(0, 0, 0, IR_ADD, E_T2, "add T2");
    step(0, 0, 0, IR_ADD, E_A3, "add T3");
    step(1, 0, 0, IR_ADD, e_a4(0), "add T4 with clear");
    step(0, 0, 0, IR_ADD, 26'd0, "after clear in T4");
    step(1, 1, 0, IR_ADD, 26'd0, "clear with start");
    step(0, 0, 0, IR_ADD, 26'd0, "clear beats start");

    // start held high for a whole instruction.
    step(0, 1, 0, IR_ADD, 26'd0, "held accept");
    step(0, 1, 0, IR_ADD, E_T0, "held T0");
    step(0, 1, 1, IR_ADD, E_T1X, "held T1");
    step(0, 1, 0, IR_ADD, E_T2, "held T2");
    step(0, 1, 0, IR_ADD, E_A3, "held T3");
    step(0, 1, 0, IR_ADD, e_a4(0), "held T4");
    step(0, 1, 0, IR_ADD, E_A5, "held T5");
    step(0, 1, 0, IR_ADD, 26'd0, "held idle");
    step(0, 1, 0, IR_ADD, E_T0, "held re-entry");
    step(1, 0, 0, IR_ADD, E_T1W, "held T1 clear");
    step(0, 0, 0, IR_ADD, 26'd0, "held cleared");

    // Random stimulus against the instruction model.
    cur_ir = IR_ADD;
    q.delete();
    sticky = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rc = ($urandom_range(0, 39) == 0);
      rs = 1'($urandom_range(0, 1));
      if (q.size() == 0) cur_ir = rand_ir();
      if (q.size() > 0 && q[0].care) rm = q[0].mr;
      else rm = 1'($urandom_range(0, 1));
      if (q.size() > 0) re = q[0].v;
      else re = sticky ? M_ILLEGAL : 26'd0;
      step(rc, rs, rm, cur_ir, re, $sformatf("random cycle %0d", n));
      if (rc) begin
        q.delete();
        sticky = 1'b0;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.ill_end) sticky = 1'b1;
      end else if (rs) begin
        sticky = 1'b0;
        plan(cur_ir);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
